serial_add32: RTL and testbench

- Multi-cycle 32-bit add/subtract unit that feeds a 4-bit ripple adder slice one nibble per clock.
- It registers the slice's sum and carry, and chains the carry into the next nibble.
- Sits between the operand/opcode register stage and the ALU result mux.
- Trades latency (WIDTH/SLICE cycles) for area.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/add_slice.sv | 24 ++
 rtl/serial_add32.sv | 137 +++++++++++++
 tb/tb_serial_add32.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle serial adder.
package alu_pkg;

    // Sequencer states of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default datapath geometry
    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SLICE   = 4;
    localparam int NUM_NIBBLES = ALU_WIDTH / ALU_SLICE;

    // Opcode encoding for op_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    // One full-adder cell per bit, carry rippling from LSB to MSB
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
        assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
        assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = w_c[SLICE];

endmodule : add_slice

// File: rtl/serial_add32.sv
// Multi-cycle add/subtract unit: one SLICE-bit nibble per clock through a
// single shared ripple slice, carry chained through a register.
module serial_add32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = ALU_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N_NIB = WIDTH / SLICE;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

    // Operands must split evenly into slices
    if ((WIDTH % SLICE) != 0) begin : g_bad_geometry
        $error("serial_add32: WIDTH must be a multiple of SLICE");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;
    logic [SLICE-1:0] w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_final;
    logic             w_c_msb;

    // Select the current nibble of each operand for the shared slice
    always_comb begin
        w_x = r_a[r_idx*SLICE +: SLICE];
        w_y = r_b[r_idx*SLICE +: SLICE];
    end

    add_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Complete result as it will look after this edge, for the zero flag
    always_comb begin
        w_final = r_result;
        w_final[r_idx*SLICE +: SLICE] = w_s;
    end

    // Carry into the MSB recovered from the MSB sum bit
    assign w_c_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[SLICE-1];

    // Sequencer and datapath registers; reset abandons any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b, seed carry with 1
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op_sub}};
                        r_carry <= (op_sub == OP_SUB);
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[r_idx*SLICE +: SLICE] <= w_s;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_c_msb ^ w_cout;
                        r_zero  <= (w_final == '0);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule : serial_add32

// File: tb/tb_serial_add32.sv
// Directed self-checking bench for serial_add32.
module tb_serial_add32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;

    int total = 0;
    int bad   = 0;

    serial_add32 #(.WIDTH(32), .SLICE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; lat = edges after the start edge
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, output int lat);
        a = ta; b = tb; op_sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=00000000", result); end
        total++; if ({cout, overflow, zero} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {cout, overflow, zero}); end
        tick();
    endtask

    task automatic test_add_basic();
        int lat;
        do_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
        // done sits in the 9th cycle counted from the start edge: 8 edges later
        total++; if (lat !== 8) begin bad++; $display("FAIL add_latency got=%0d want=8", lat); end
        total++; if (result !== 32'h0000_0008) begin bad++; $display("FAIL add_result got=%h want=00000008", result); end
        total++; if ({cout, overflow, zero} !== 3'b000) begin bad++; $display("FAIL add_flags got=%b want=000", {cout, overflow, zero}); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_pulse got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_carry_chain();
        int lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL chain_latency got=%0d want=8", lat); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL chain_result got=%h want=00000000", result); end
        total++; if ({cout, overflow, zero} !== 3'b101) begin bad++; $display("FAIL chain_flags got=%b want=101", {cout, overflow, zero}); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 32'h1111_1111; b = 32'h1111_1111; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        // four nibbles done, idx=4; previous result was zero
        total++; if (result !== 32'h0000_2222) begin bad++; $display("FAIL mid_partial got=%h want=00002222", result); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mid_rst_result got=%h want=00000000", result); end
        total++; if ({cout, overflow, zero} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got=%b want=000", {cout, overflow, zero}); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_quiet got=%0d want=0", seen); end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL ovf_add_result got=%h want=80000000", result); end
        total++; if ({cout, overflow, zero} !== 3'b010) begin bad++; $display("FAIL ovf_add_flags got=%b want=010", {cout, overflow, zero}); end
        tick();
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        total++; if (result !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_sub_result got=%h want=7fffffff", result); end
        total++; if ({cout, overflow, zero} !== 3'b110) begin bad++; $display("FAIL ovf_sub_flags got=%b want=110", {cout, overflow, zero}); end
        tick();
    endtask

    task automatic test_sub_borrow();
        int lat;
        do_op(32'h0000_0003, 32'h0000_0005, 1'b1, lat);
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_borrow_result got=%h want=fffffffe", result); end
        total++; if ({cout, overflow, zero} !== 3'b000) begin bad++; $display("FAIL sub_borrow_flags got=%b want=000", {cout, overflow, zero}); end
        tick();
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
        total++; if (result !== 32'h0) begin bad++; $display("FAIL sub_equal_result got=%h want=00000000", result); end
        total++; if ({cout, overflow, zero} !== 3'b101) begin bad++; $display("FAIL sub_equal_flags got=%b want=101", {cout, overflow, zero}); end
        tick();
    endtask

    task automatic test_ignored_start();
        int n_done, done_at, busy_err;
        logic [31:0] res_at_done;
        n_done = 0; done_at = -1; busy_err = 0; res_at_done = '0;
        a = 32'h0000_0005; b = 32'h0000_0003; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            // second request three cycles into RUN, with different operands
            if (k == 4) begin a = 32'd100; b = 32'd200; op_sub = 1'b1; start = 1'b1; end
            else start = 1'b0;
            if (k <= 8 && busy !== 1'b1) busy_err++;
            tick();
            if (done === 1'b1) begin
                n_done++;
                done_at = k;
                res_at_done = result;
                if (busy !== 1'b1) busy_err++;
            end
        end
        total++; if (n_done !== 1 || done_at !== 8) begin bad++; $display("FAIL ign_done got count=%0d at=%0d want 1 at 8", n_done, done_at); end
        total++; if (res_at_done !== 32'h0000_0008) begin bad++; $display("FAIL ign_result got=%h want=00000008", res_at_done); end
        total++; if (busy_err !== 0) begin bad++; $display("FAIL ign_busy got=%0d want=0", busy_err); end
    endtask

    task automatic test_back_to_back();
        int n_done, misplaced;
        logic [31:0] r1, r2;
        logic b9, b10;
        n_done = 0; misplaced = 0; r1 = '0; r2 = '0; b9 = 1'bx; b10 = 1'bx;
        a = 32'd1; b = 32'd1; op_sub = 1'b0; start = 1'b1;
        tick();
        // operand change while running must not affect the first op
        a = 32'd5;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 9)  b9 = busy;
            if (k == 10) b10 = busy;
            if (done === 1'b1) begin
                n_done++;
                if (k == 8) r1 = result;
                else if (k == 18) r2 = result;
                else misplaced++;
            end
            if (k == 18) start = 1'b0;
        end
        start = 1'b0;
        total++; if (n_done !== 2 || misplaced !== 0) begin bad++; $display("FAIL b2b_done got count=%0d misplaced=%0d want 2 0", n_done, misplaced); end
        total++; if (r1 !== 32'd2 || r2 !== 32'd6) begin bad++; $display("FAIL b2b_results got=%h,%h want=00000002,00000006", r1, r2); end
        total++; if (b9 !== 1'b0 || b10 !== 1'b1) begin bad++; $display("FAIL b2b_accept_edge got busy9=%b busy10=%b want 0 1", b9, b10); end
    endtask

    task automatic test_rst_with_start();
        int seen;
        a = 32'h0000_0009; b = 32'h0000_0001; op_sub = 1'b0;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0 || result !== 32'h0) begin bad++; $display("FAIL rst_start got busy=%b result=%h want 0 00000000", busy, result); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_start_quiet got=%0d want=0", seen); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        test_reset();
        test_add_basic();
        test_carry_chain();
        test_reset_mid_run();
        test_overflow();
        test_sub_borrow();
        test_ignored_start();
        test_back_to_back();
        test_rst_with_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add32
